hpi_access_sequencer: RTL and testbench
=======================================

Name: hpi_access_sequencer

Overview:
- Shares the USB OTG host-port interface (CY7C67200 HPI) between two requesters. Port 0 is the Nios software bridge; port 1 is the hardware keyboard poller.
- Sequences each access with programmable setup, strobe, hold and recovery timing on the HPI pins.
- Generates the chip's power-up reset pulse.
- Sits between the processor system / poller and the top-level HPI pads.

Parameters:
- SETUP_CYC, 1, cycles with cs_n low and address valid before the strobe (≥1)
- STROBE_CYC, 4, cycles with r_n or w_n low (≥1)
- HOLD_CYC, 1, cycles with strobe high, cs_n low and data held (≥1)
- RECOV_CYC, 2, idle cycles with all controls deasserted after each access (≥1)
- RST_CYC, 16, cycles hpi_reset_n is held low after reset release (≥1)

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  port 0 request; fields stable while high
- req0_we  in  1  1 = write, 0 = read
- req0_addr  in  2  HPI register select
- req0_wdata  in  16  write data
- req0_lock  in  1  hold HPI across consecutive port 0 accesses (macro-gated)
- req0_ack  out  1  one-cycle completion pulse
- req0_rdata  out  16  read data, valid from the ack cycle until the next port 0 ack
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ack, req1_rdata: same as port 0, no lock
- init_done  out  1  high once the HPI reset pulse is complete
- hpi_addr  out  2  HPI address pins
- hpi_cs_n, hpi_r_n, hpi_w_n  out  1 each  HPI strobes, active low
- hpi_reset_n  out  1  HPI chip reset, active low
- hpi_dout  out  16  write data to pad
- hpi_doe  out  1  pad output enable
- hpi_din  in  16  read data from pad

Behaviour:
- Async reset values:
  - state=INIT, hpi_reset_n=0, hpi_cs_n=hpi_r_n=hpi_w_n=1, hpi_doe=0, hpi_addr=0, hpi_dout=0
  - both acks 0, both rdata 0, init_done=0, last_gnt=1, lock_held=0
- INIT: counts RST_CYC cycles with hpi_reset_n=0, then drives hpi_reset_n=1, sets init_done=1, goes to IDLE. Requests are ignored in INIT.
- IDLE: requests are sampled only here.
  - Only one valid → grant it.
  - Both valid → grant the port that is not last_gnt (round-robin).
  - On grant: latch we/addr/wdata, update last_gnt, go to SETUP.
- SETUP (SETUP_CYC cycles): hpi_cs_n=0, hpi_addr driven. For a write, hpi_dout is driven and hpi_doe=1.
- STROBE (STROBE_CYC cycles): r_n=0 for a read, w_n=0 for a write. For a read, hpi_din is captured into the granted port's rdata at the clock edge ending the last STROBE cycle.
- HOLD (HOLD_CYC cycles): strobes high, cs_n=0, write data and hpi_doe held. The granted port's ack=1 in the last HOLD cycle only.
- RECOVER (RECOV_CYC cycles): cs_n=1, hpi_doe=0, then back to IDLE.
- Access timing: 1 IDLE + S+W+H+R cycles from valid to the next sample point; 9 cycles with defaults. At most one access is in flight.
- Requester rule: drop valid on the edge after ack, or a new access follows. Because RECOV_CYC ≥ 1, a registered deassert is always seen before IDLE.
- Signal rules:
  - r_n and w_n are never low together.
  - cs_n stays low from SETUP through HOLD with no glitch.
  - hpi_addr changes only while cs_n=1.
- The pad tristate is external: hpi_doe gates hpi_dout.
- A reset assertion mid-access aborts immediately to the reset values and reruns INIT; no ack is issued.

Optional Feature:
- Macro: HPI_LOCK_EN.
- Defined:
  - If req0_lock=1 when port 0 is granted, lock_held is set.
  - While lock_held=1, IDLE grants only port 0; req1 waits even if port 0 is idle.
  - lock_held clears in IDLE when req0_lock=0.
  - Purpose: atomic ADDRESS-write then DATA-read sequences.
- Undefined: req0_lock is ignored, lock_held is constant 0, and arbitration is pure round-robin.

Decomposition:
- Package hpi_pkg holds:
  - state enum {INIT, IDLE, SETUP, STROBE, HOLD, RECOVER}
  - HPI register constants: HPI_DATA=2'd0, HPI_MAILBOX=2'd1, HPI_ADDRESS=2'd2, HPI_STATUS=2'd3
  - phase counter width
- One sub-module, hpi_cycle_engine: the phase FSM, timing counters and pin drive. The top level holds arbitration, lock, per-port rdata and ack routing.

Test Plan:
- Reset release → hpi_reset_n low for exactly 16 cycles; init_done rises the same cycle; req0_valid asserted during INIT gets no ack until after init_done.
- Port 0 write addr=2 wdata=16'h1000:
  - cs_n low for 6 cycles, w_n low for 4, hpi_doe high for 6, r_n stays 1.
  - ack0 pulses 1 cycle in the 6th cs_n-low cycle; next IDLE 2 cycles later.
- Port 1 read addr=0, hpi_din=16'hBEEF during STROBE → req1_rdata=16'hBEEF at ack1; req0_rdata unchanged.
- Both valid continuously after reset → grants alternate 0,1,0,1; no two acks in the same cycle; 9-cycle spacing between acks.
- HPI_LOCK_EN, req0_lock=1 across 3 port 0 accesses with req1_valid high → three ack0 before any ack1; req1 is served next after lock drops.
- reset_reset_n pulsed low mid-STROBE → cs_n, r_n, w_n =1 and hpi_reset_n=0 immediately; no ack; INIT reruns for 16 cycles.

Source files
------------

// File: rtl/hpi_access_sequencer_pkg.sv
// Shared types and constants for the HPI access sequencer: phase FSM states,
// CY7C67200 HPI register selects and the phase counter type.
package hpi_pkg;

  // Wide enough for every timing parameter, including the reset pulse length.
  localparam int unsigned PhaseCntW = 8;

  typedef logic [PhaseCntW-1:0] phase_cnt_t;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StRecover
  } hpi_state_e;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // Counter value seen in the final cycle of a phase lasting `cycles` cycles.
  function automatic phase_cnt_t last_cnt(input int unsigned cycles);
    return phase_cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/hpi_access_sequencer_cycle_engine.sv
// HPI phase engine: runs the chip reset pulse, then sequences one access at a
// time through setup/strobe/hold/recover with glitch-free registered pin drive.
module hpi_cycle_engine
  import hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned RECOV_CYC  = 2,
  parameter int unsigned RST_CYC    = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [15:0] wdata_i,
  output logic        idle_o,
  output logic        ack_o,
  output logic        capture_o,
  output logic        init_done_o,
  output logic [1:0]  hpi_addr_o,
  output logic        hpi_cs_n_o,
  output logic        hpi_r_n_o,
  output logic        hpi_w_n_o,
  output logic        hpi_reset_n_o,
  output logic [15:0] hpi_dout_o,
  output logic        hpi_doe_o
);

  hpi_state_e  state_q, state_d;
  phase_cnt_t  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        cs_n_q, r_n_q, w_n_q, doe_q, ack_q, rst_n_q;
  logic        active_d, strobe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + phase_cnt_t'(1);
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StInit: begin
        if (cnt_q == last_cnt(RST_CYC)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StIdle: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = StSetup;
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end
      end
      StSetup: begin
        if (cnt_q == last_cnt(SETUP_CYC)) begin
          state_d = StStrobe;
          cnt_d   = '0;
        end
      end
      StStrobe: begin
        if (cnt_q == last_cnt(STROBE_CYC)) begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold: begin
        if (cnt_q == last_cnt(HOLD_CYC)) begin
          state_d = StRecover;
          cnt_d   = '0;
        end
      end
      StRecover: begin
        if (cnt_q == last_cnt(RECOV_CYC)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  // Pins are registered from the next state so they change cleanly on the edge.
  assign active_d = state_d inside {StSetup, StStrobe, StHold};
  assign strobe_d = (state_d == StStrobe);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StInit;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= HPI_DATA;
      wdata_q <= '0;
      cs_n_q  <= 1'b1;
      r_n_q   <= 1'b1;
      w_n_q   <= 1'b1;
      doe_q   <= 1'b0;
      ack_q   <= 1'b0;
      rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cs_n_q  <= !active_d;
      r_n_q   <= !(strobe_d && !we_d);
      w_n_q   <= !(strobe_d && we_d);
      doe_q   <= active_d && we_d;
      ack_q   <= (state_d == StHold) && (cnt_d == last_cnt(HOLD_CYC));
      rst_n_q <= (state_d != StInit);
    end
  end

  assign idle_o        = (state_q == StIdle);
  assign ack_o         = ack_q;
  assign capture_o     = (state_q == StStrobe) && (cnt_q == last_cnt(STROBE_CYC)) && !we_q;
  assign init_done_o   = rst_n_q;
  assign hpi_addr_o    = addr_q;
  assign hpi_cs_n_o    = cs_n_q;
  assign hpi_r_n_o     = r_n_q;
  assign hpi_w_n_o     = w_n_q;
  assign hpi_reset_n_o = rst_n_q;
  assign hpi_dout_o    = wdata_q;
  assign hpi_doe_o     = doe_q;

endmodule

// File: rtl/hpi_access_sequencer.sv
// Two-port HPI access sequencer: round-robin arbitration between the Nios bridge
// (port 0) and keyboard poller (port 1). Build with HPI_LOCK_EN for port 0 locking.
module hpi_access_sequencer
  import hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned RECOV_CYC  = 2,
  parameter int unsigned RST_CYC    = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [1:0]  req0_addr,
  input  logic [15:0] req0_wdata,
  input  logic        req0_lock,
  output logic        req0_ack,
  output logic [15:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [1:0]  req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        req1_ack,
  output logic [15:0] req1_rdata,
  output logic        init_done,
  output logic [1:0]  hpi_addr,
  output logic        hpi_cs_n,
  output logic        hpi_r_n,
  output logic        hpi_w_n,
  output logic        hpi_reset_n,
  output logic [15:0] hpi_dout,
  output logic        hpi_doe,
  input  logic [15:0] hpi_din
);

  logic        eng_idle, eng_ack, eng_capture;
  logic        start, sel;
  logic        last_gnt_q, last_gnt_d;
  logic        lock_held_q, lock_held_d;
  logic        lock_req, lock_eff;
  logic        cmd_we;
  logic [1:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic [15:0] rdata0_q, rdata1_q;

`ifdef HPI_LOCK_EN
  assign lock_req = req0_lock;
`else
  logic unused_lock;
  assign unused_lock = req0_lock;
  assign lock_req    = 1'b0;
`endif

  // A held lock only reserves the engine while port 0 keeps asking for it.
  assign lock_eff = lock_held_q && lock_req;

  always_comb begin
    start       = 1'b0;
    sel         = last_gnt_q;
    last_gnt_d  = last_gnt_q;
    lock_held_d = lock_held_q;
    if (eng_idle) begin
      if (lock_eff) begin
        start = req0_valid;
        sel   = 1'b0;
      end else if (req0_valid && req1_valid) begin
        start = 1'b1;
        sel   = ~last_gnt_q;
      end else if (req0_valid) begin
        start = 1'b1;
        sel   = 1'b0;
      end else if (req1_valid) begin
        start = 1'b1;
        sel   = 1'b1;
      end
      if (start) begin
        last_gnt_d = sel;
      end
      if (start && !sel) begin
        lock_held_d = lock_req;
      end else if (!lock_req) begin
        lock_held_d = 1'b0;
      end
    end
  end

  assign cmd_we    = sel ? req1_we    : req0_we;
  assign cmd_addr  = sel ? req1_addr  : req0_addr;
  assign cmd_wdata = sel ? req1_wdata : req0_wdata;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      last_gnt_q  <= 1'b1;
      lock_held_q <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      lock_held_q <= lock_held_d;
      // last_gnt_q names the port owning the access currently in flight.
      if (eng_capture && !last_gnt_q) begin
        rdata0_q <= hpi_din;
      end
      if (eng_capture && last_gnt_q) begin
        rdata1_q <= hpi_din;
      end
    end
  end

  assign req0_ack   = eng_ack && !last_gnt_q;
  assign req1_ack   = eng_ack && last_gnt_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

  hpi_cycle_engine #(
    .SETUP_CYC  (SETUP_CYC),
    .STROBE_CYC (STROBE_CYC),
    .HOLD_CYC   (HOLD_CYC),
    .RECOV_CYC  (RECOV_CYC),
    .RST_CYC    (RST_CYC)
  ) u_engine (
    .clk_i         (clk_clk),
    .rst_ni        (reset_reset_n),
    .start_i       (start),
    .we_i          (cmd_we),
    .addr_i        (cmd_addr),
    .wdata_i       (cmd_wdata),
    .idle_o        (eng_idle),
    .ack_o         (eng_ack),
    .capture_o     (eng_capture),
    .init_done_o   (init_done),
    .hpi_addr_o    (hpi_addr),
    .hpi_cs_n_o    (hpi_cs_n),
    .hpi_r_n_o     (hpi_r_n),
    .hpi_w_n_o     (hpi_w_n),
    .hpi_reset_n_o (hpi_reset_n),
    .hpi_dout_o    (hpi_dout),
    .hpi_doe_o     (hpi_doe)
  );

endmodule

// File: tb/tb_hpi_access_sequencer.sv
// Bench for hpi_access_sequencer: directed scenarios plus random requesters, all
// checked cycle by cycle against a transaction-level timing model.
module tb_hpi_access_sequencer;
  import hpi_pkg::*;

  localparam int S = 1, W = 4, H = 1, R = 2, RST = 16;
  localparam int AckOff = S + W + H;
  localparam int Period = S + W + H + R + 1;

  logic        clk_clk = 1'b0, reset_reset_n = 1'b1;
  logic        req0_valid = 0, req0_we = 0, req0_lock = 0, req1_valid = 0, req1_we = 0;
  logic [1:0]  req0_addr = 0, req1_addr = 0;
  logic [15:0] req0_wdata = 0, req1_wdata = 0, hpi_din = 0;
  logic        req0_ack, req1_ack, init_done, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n, hpi_doe;
  logic [15:0] req0_rdata, req1_rdata, hpi_dout;
  logic [1:0]  hpi_addr;

  always #5 clk_clk = ~clk_clk;

  hpi_access_sequencer #(
    .SETUP_CYC(S), .STROBE_CYC(W), .HOLD_CYC(H), .RECOV_CYC(R), .RST_CYC(RST)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_lock(req0_lock), .req0_ack(req0_ack),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_rdata(req1_rdata),
    .init_done(init_done), .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n), .hpi_r_n(hpi_r_n),
    .hpi_w_n(hpi_w_n), .hpi_reset_n(hpi_reset_n), .hpi_dout(hpi_dout), .hpi_doe(hpi_doe),
    .hpi_din(hpi_din)
  );

  // Requester side
  logic        v[2], rw[2], ack_seen[2];
  logic [1:0]  ra[2];
  logic [15:0] rd[2];
  int          prob[2];
  logic        lk0 = 1'b0, lock_rand = 1'b0, din_rand = 1'b1;

  // Reference model: one transaction in flight, timed from its grant cycle g
  int          n, g, t_port;
  bit          busy, t_we, m_last, m_lock;
  logic [1:0]  t_addr;
  logic [15:0] t_wd;
  logic [15:0] m_rdata[2];

  int  checks = 0, fails = 0;
  bit  rst_hi_seen, check_spacing;
  int  last_ack_n, last_ack_port, first_ack0_n;
  int  ack_cnt[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic drive();
    req0_valid = v[0]; req0_we = rw[0]; req0_addr = ra[0]; req0_wdata = rd[0];
    req0_lock  = lk0;
    req1_valid = v[1]; req1_we = rw[1]; req1_addr = ra[1]; req1_wdata = rd[1];
  endtask

  task automatic model_step();
    logic       e_cs_n, e_r_n, e_w_n, e_doe;
    logic [1:0] e_ack;
    int         d, pick;
    bit         lk;
    e_cs_n = 1; e_r_n = 1; e_w_n = 1; e_doe = 0; e_ack = 2'b00;
    if (busy && n >= g + Period) busy = 0;
    if (busy) begin
      d = n - g;
      if (d >= 1 && d <= AckOff) begin
        e_cs_n = 0;
        e_doe  = t_we;
      end
      if (d > S && d <= S + W) begin
        if (t_we) e_w_n = 0;
        else e_r_n = 0;
      end
      if (d == S + W && !t_we) m_rdata[t_port] = hpi_din;
      if (d == AckOff) e_ack[t_port] = 1'b1;
    end
    check("cs_n", 32'(hpi_cs_n), 32'(e_cs_n));
    check("r_n", 32'(hpi_r_n), 32'(e_r_n));
    check("w_n", 32'(hpi_w_n), 32'(e_w_n));
    check("doe", 32'(hpi_doe), 32'(e_doe));
    check("ack0", 32'(req0_ack), 32'(e_ack[0]));
    check("ack1", 32'(req1_ack), 32'(e_ack[1]));
    check("reset_n", 32'(hpi_reset_n), 32'(n >= RST));
    check("init_done", 32'(init_done), 32'(n >= RST));
    if (!e_cs_n) check("addr", 32'(hpi_addr), 32'(t_addr));
    if (e_doe) check("dout", 32'(hpi_dout), 32'(t_wd));
    if (e_ack != 2'b00) begin
      check("rdata0", 32'(req0_rdata), 32'(m_rdata[0]));
      check("rdata1", 32'(req1_rdata), 32'(m_rdata[1]));
    end
    if (!busy && n >= RST) begin
      lk = 0;
`ifdef HPI_LOCK_EN
      if (m_lock && !req0_lock) m_lock = 0;
      lk = m_lock;
`endif
      pick = -1;
      if (lk) begin
        if (req0_valid) pick = 0;
      end else if (req0_valid && req1_valid) pick = m_last ? 0 : 1;
      else if (req0_valid) pick = 0;
      else if (req1_valid) pick = 1;
      if (pick >= 0) begin
        busy   = 1;
        g      = n;
        t_port = pick;
        t_we   = (pick == 0) ? req0_we : req1_we;
        t_addr = (pick == 0) ? req0_addr : req1_addr;
        t_wd   = (pick == 0) ? req0_wdata : req1_wdata;
        m_last = (pick == 1);
`ifdef HPI_LOCK_EN
        if (pick == 0) m_lock = req0_lock;
`endif
      end
    end
  endtask

  task automatic observe();
    int p;
    if (req0_ack || req1_ack) begin
      p = req1_ack ? 1 : 0;
      if (check_spacing && last_ack_n >= 0) begin
        check("ack_spacing", n - last_ack_n, Period);
        check("ack_alternate", p, 1 - last_ack_port);
      end
      if (p == 0 && first_ack0_n < 0) first_ack0_n = n;
      last_ack_n    = n;
      last_ack_port = p;
      ack_cnt[p]++;
    end
    if (req0_ack) ack_seen[0] = 1;
    if (req1_ack) ack_seen[1] = 1;
    if (!rst_hi_seen && hpi_reset_n) begin
      rst_hi_seen = 1;
      check("reset_pulse_len", n, RST);
      check("init_done_with_reset", 32'(init_done), 32'd1);
    end
  endtask

  task automatic step();
    @(posedge clk_clk);
    #1;
    n++;
    for (int p = 0; p < 2; p++) begin
      if (ack_seen[p]) begin
        v[p] = 0;
        ack_seen[p] = 0;
      end else if (!v[p] && $urandom_range(99) < prob[p]) begin
        v[p]  = 1;
        rw[p] = 1'($urandom);
        ra[p] = 2'($urandom);
        rd[p] = 16'($urandom);
        if (p == 0 && lock_rand) lk0 = ($urandom_range(3) == 0);
      end
    end
    if (din_rand) hpi_din = 16'($urandom);
    drive();
    @(negedge clk_clk);
    model_step();
    observe();
  endtask

  task automatic do_reset();
    reset_reset_n = 0;
    #1;
    check("rst_cs_n", 32'(hpi_cs_n), 32'd1);
    check("rst_r_n", 32'(hpi_r_n), 32'd1);
    check("rst_w_n", 32'(hpi_w_n), 32'd1);
    check("rst_doe", 32'(hpi_doe), 32'd0);
    check("rst_reset_n", 32'(hpi_reset_n), 32'd0);
    check("rst_acks", {30'd0, req1_ack, req0_ack}, 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rdata", {req1_rdata, req0_rdata}, 32'd0);
    repeat (2) @(posedge clk_clk);
    #1;
    reset_reset_n = 1;
    n = 0; busy = 0; m_last = 1; m_lock = 0; rst_hi_seen = 0;
    for (int p = 0; p < 2; p++) begin
      m_rdata[p]  = '0;
      ack_seen[p] = 0;
    end
  endtask

  task automatic drain();
    prob[0] = 0; prob[1] = 0; lk0 = 0; lock_rand = 0;
    for (int i = 0; i < 60 && (v[0] || v[1] || busy); i++) step();
    check("drain_done", 32'(v[0] || v[1] || busy), 32'd0);
  endtask

  initial begin
    int base0, base1, tot;
    bit found;
    for (int p = 0; p < 2; p++) begin
      v[p] = 0; rw[p] = 0; ra[p] = 0; rd[p] = 0; prob[p] = 0; ack_seen[p] = 0;
      ack_cnt[p] = 0; m_rdata[p] = 0;
    end
    n = 0; busy = 0; check_spacing = 0; last_ack_n = -1; last_ack_port = 0;
    first_ack0_n = -1;

    // Port 0 write requested throughout INIT
    v[0] = 1; rw[0] = 1; ra[0] = HPI_ADDRESS; rd[0] = 16'h1000;
    drive();
    #2;
    do_reset();
    repeat (RST + Period + 4) step();
    check("first_ack0_cycle", first_ack0_n, RST + AckOff);
    check("ack_counts_write", {ack_cnt[1][15:0], ack_cnt[0][15:0]}, 32'h0000_0001);

    // Port 1 read with a fixed pad value
    din_rand = 0; hpi_din = 16'hBEEF;
    v[1] = 1; rw[1] = 0; ra[1] = HPI_DATA; rd[1] = 16'h0;
    repeat (Period + 3) step();
    check("rdata1_read", 32'(req1_rdata), 32'h0000_BEEF);
    check("rdata0_kept", 32'(req0_rdata), 32'h0);
    din_rand = 1;

    // Both ports requesting back to back
    base0 = ack_cnt[0]; base1 = ack_cnt[1];
    last_ack_n = -1; check_spacing = 1;
    prob[0] = 100; prob[1] = 100;
    repeat (5 * Period) step();
    check_spacing = 0;
    check("rr_both_served", 32'((ack_cnt[0] - base0 >= 2) && (ack_cnt[1] - base1 >= 2)), 32'd1);
    drain();

    // Random traffic
    prob[0] = 30; prob[1] = 30; lock_rand = 1;
    repeat (400) step();
    drain();

    // Reset mid-strobe
    prob[0] = 100; prob[1] = 100;
    found = 0;
    for (int i = 0; i < 3 * Period && !found; i++) begin
      step();
      if (busy && (n - g) > S && (n - g) <= S + W) found = 1;
    end
    check("strobe_reached", 32'(found), 32'd1);
    prob[0] = 0; prob[1] = 0;
    do_reset();
    repeat (RST + 2) step();
    drain();

`ifdef HPI_LOCK_EN
    // Locked port 0 sequence holds off port 1
    base0 = ack_cnt[0]; base1 = ack_cnt[1];
    lk0 = 1; prob[0] = 100;
    step();
    step();
    prob[1] = 100;
    for (int i = 0; i < 6 * Period && (ack_cnt[0] - base0 < 3); i++) step();
    check("lock_ack0_count", ack_cnt[0] - base0, 3);
    check("lock_no_ack1", ack_cnt[1] - base1, 0);
    lk0 = 0;
    tot = ack_cnt[0] + ack_cnt[1];
    for (int i = 0; i < 3 * Period && (ack_cnt[0] + ack_cnt[1] == tot); i++) step();
    check("unlock_next_port", last_ack_port, 1);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
